// File: rtl/adt7420_i2c_target_emu.sv
// ============================================================================
// Module  : adt7420_i2c_target_emu
// Brief   : I2C target emulating an ADT7420 temperature sensor (temp/status/
//           config/ID registers). Optional SCL stretching: ADT_EMU_STRETCH_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module adt7420_i2c_target_emu #(
    parameter logic [6:0] I2C_ADDR7   = 7'h4B,
    parameter int         FILT_LEN    = 3,
    parameter int         STRETCH_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        scl_oen,
    output logic        sda_oen,
    input  logic [12:0] temp_c16,
    input  logic        temp_load,
    output logic [7:0]  cfg_reg,
    output logic        busy,
    output logic        xfer_done
);

    localparam logic [2:0] c_FILT_TOP = 3'(FILT_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_scl_s, r_sda_s;
    logic [2:0]  r_scl_cnt, r_sda_cnt;
    logic        r_scl_f, r_sda_f, r_scl_d, r_sda_d;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [7:0]  r_rx, r_ptr, r_cfg;
    logic [6:0]  r_tx;
    logic [12:0] r_shadow;
    logic [4:0]  r_tx_latch;
    logic        r_nack, r_sda_oen, r_busy, r_done;
    logic        w_sda_oen_nxt, w_busy_nxt, w_done_nxt;
    logic        w_ack_end, w_load_tx, w_shift_tx, w_ptr_load, w_ptr_inc, w_cfg_we;
    logic        w_str, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]  w_rd_byte;

    // Input conditioning: 2-FF synchronizer, then a level is accepted only
    // once the synchronized value has differed for FILT_LEN consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_s   <= 2'b11;
            r_sda_s   <= 2'b11;
            r_scl_cnt <= '0;
            r_sda_cnt <= '0;
            r_scl_f   <= 1'b1;
            r_sda_f   <= 1'b1;
            r_scl_d   <= 1'b1;
            r_sda_d   <= 1'b1;
        end else begin
            r_scl_s <= {r_scl_s[0], scl_in};
            r_sda_s <= {r_sda_s[0], sda_in};
            if (r_scl_s[1] == r_scl_f) begin
                r_scl_cnt <= '0;
            end else if (r_scl_cnt == c_FILT_TOP) begin
                r_scl_f   <= r_scl_s[1];
                r_scl_cnt <= '0;
            end else begin
                r_scl_cnt <= r_scl_cnt + 3'd1;
            end
            if (r_sda_s[1] == r_sda_f) begin
                r_sda_cnt <= '0;
            end else if (r_sda_cnt == c_FILT_TOP) begin
                r_sda_f   <= r_sda_s[1];
                r_sda_cnt <= '0;
            end else begin
                r_sda_cnt <= r_sda_cnt + 3'd1;
            end
            r_scl_d <= r_scl_f;
            r_sda_d <= r_sda_f;
        end
    end

    assign w_scl_rise = r_scl_f & ~r_scl_d & ~w_str;
    assign w_scl_fall = ~r_scl_f & r_scl_d & ~w_str;
    assign w_start    = r_scl_f & r_scl_d & r_sda_d & ~r_sda_f;
    assign w_stop     = r_scl_f & r_scl_d & ~r_sda_d & r_sda_f;

    // Address 0x01 is served from the latch taken when 0x00 was read.
    always_comb begin
        w_rd_byte = 8'h00;
        case (r_ptr)
            8'h00:   w_rd_byte = r_shadow[12:5];
            8'h01:   w_rd_byte = {r_tx_latch, 3'b000};
            8'h03:   w_rd_byte = r_cfg;
            8'h0B:   w_rd_byte = 8'hCB;
            default: w_rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_sda_oen_nxt = r_sda_oen;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_ack_end     = 1'b0;
        w_load_tx     = 1'b0;
        w_shift_tx    = 1'b0;
        w_ptr_load    = 1'b0;
        w_ptr_inc     = 1'b0;
        w_cfg_we      = 1'b0;
        if (w_stop) begin
            w_state_nxt   = S_IDLE;
            w_cnt_nxt     = '0;
            w_sda_oen_nxt = 1'b1;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = r_busy;
        end else if (w_start) begin
            w_state_nxt   = S_ADDR;
            w_cnt_nxt     = '0;
            w_sda_oen_nxt = 1'b1;
        end else begin
            case (r_state)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (w_scl_rise && r_cnt != 4'd8) w_cnt_nxt = r_cnt + 4'd1;
                    if (w_scl_fall && r_cnt == 4'd8) begin
                        w_cnt_nxt     = '0;
                        w_sda_oen_nxt = 1'b0;
                        if (r_state == S_ADDR) begin
                            if (r_rx[7:1] == I2C_ADDR7) begin
                                w_state_nxt = S_ADDR_ACK;
                                w_busy_nxt  = 1'b1;
                            end else begin
                                w_state_nxt   = S_IDLE;
                                w_sda_oen_nxt = 1'b1;
                                w_busy_nxt    = 1'b0;
                            end
                        end else if (r_state == S_PTR) begin
                            w_state_nxt = S_PTR_ACK;
                            w_ptr_load  = 1'b1;
                        end else begin
                            w_state_nxt = S_WDATA_ACK;
                            w_cfg_we    = (r_ptr == 8'h03);
                            w_ptr_inc   = 1'b1;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_ack_end = 1'b1;
                        if (r_rx[0]) begin
                            w_state_nxt   = S_RDATA;
                            w_load_tx     = 1'b1;
                            w_sda_oen_nxt = w_rd_byte[7];
                        end else begin
                            w_state_nxt   = S_PTR;
                            w_sda_oen_nxt = 1'b1;
                        end
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_ack_end     = 1'b1;
                        w_state_nxt   = S_WDATA;
                        w_sda_oen_nxt = 1'b1;
                    end
                end
                S_RDATA: begin
                    if (w_scl_rise && r_cnt != 4'd8) w_cnt_nxt = r_cnt + 4'd1;
                    if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_state_nxt   = S_RACK;
                            w_cnt_nxt     = '0;
                            w_sda_oen_nxt = 1'b1;
                            w_ptr_inc     = 1'b1;
                        end else begin
                            w_shift_tx    = 1'b1;
                            w_sda_oen_nxt = r_tx[6];
                        end
                    end
                end
                S_RACK: begin
                    if (w_scl_fall) begin
                        w_ack_end = 1'b1;
                        if (r_nack) begin
                            w_state_nxt   = S_IDLE;
                            w_sda_oen_nxt = 1'b1;
                        end else begin
                            w_state_nxt   = S_RDATA;
                            w_load_tx     = 1'b1;
                            w_sda_oen_nxt = w_rd_byte[7];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sda_oen  <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rx       <= '0;
            r_tx       <= '0;
            r_nack     <= 1'b0;
            r_ptr      <= '0;
            r_cfg      <= '0;
            r_shadow   <= '0;
            r_tx_latch <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sda_oen <= w_sda_oen_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            if (w_scl_rise && (r_state == S_ADDR || r_state == S_PTR || r_state == S_WDATA))
                r_rx <= {r_rx[6:0], r_sda_f};
            if (w_scl_rise && r_state == S_RACK)
                r_nack <= r_sda_f;
            if (w_load_tx) begin
                r_tx <= w_rd_byte[6:0];
                if (r_ptr == 8'h00) r_tx_latch <= r_shadow[4:0];
            end else if (w_shift_tx) begin
                r_tx <= {r_tx[5:0], 1'b0};
            end
            if (w_ptr_load)     r_ptr <= r_rx;
            else if (w_ptr_inc) r_ptr <= r_ptr + 8'd1;
            if (w_cfg_we)       r_cfg <= r_rx;
            if (temp_load)      r_shadow <= temp_c16;
        end
    end

`ifdef ADT_EMU_STRETCH_EN
    logic        r_scl_oen;
    logic [15:0] r_str_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_oen <= 1'b1;
            r_str_cnt <= '0;
        end else if (w_ack_end) begin
            r_scl_oen <= 1'b0;
            r_str_cnt <= 16'(STRETCH_CYC - 1);
        end else if (!r_scl_oen) begin
            if (r_str_cnt == 16'd0) r_scl_oen <= 1'b1;
            else                    r_str_cnt <= r_str_cnt - 16'd1;
        end
    end

    assign w_str   = ~r_scl_oen;
    assign scl_oen = r_scl_oen;
`else
    logic w_unused_stretch;
    assign w_unused_stretch = (STRETCH_CYC > 0) ^ w_ack_end;
    assign w_str   = 1'b0;
    assign scl_oen = 1'b1;
`endif

    assign sda_oen   = r_sda_oen;
    assign cfg_reg   = r_cfg;
    assign busy      = r_busy;
    assign xfer_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_adt7420_i2c_target_emu.sv
// ============================================================================
// Module  : tb_adt7420_i2c_target_emu
// Brief   : Directed I2C initiator bench for adt7420_i2c_target_emu.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_adt7420_i2c_target_emu;

    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic [12:0] temp_c16 = '0;
    logic        temp_load = 1'b0;
    logic        scl_oen, sda_oen, busy, xfer_done;
    logic [7:0]  cfg_reg;
    wire         scl_bus = m_scl & scl_oen;
    wire         sda_bus = m_sda & sda_oen;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   done_ref;
    logic mon_en = 1'b0;
    logic sda_low_seen = 1'b0;
    logic ack;
    logic b;
    logic [7:0] d;

    adt7420_i2c_target_emu dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_bus),
        .sda_in    (sda_bus),
        .scl_oen   (scl_oen),
        .sda_oen   (sda_oen),
        .temp_c16  (temp_c16),
        .temp_load (temp_load),
        .cfg_reg   (cfg_reg),
        .busy      (busy),
        .xfer_done (xfer_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (xfer_done) done_cnt++;
        if (mon_en && !sda_oen) sda_low_seen = 1'b1;
    end

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; m_scl = 1'b1; wt(T);
        m_sda = 1'b0; wt(T);
        m_scl = 1'b0; wt(T);
    endtask

    task automatic i2c_rstart();
        m_sda = 1'b1; wt(T);
        m_scl = 1'b1; wt(T);
        m_sda = 1'b0; wt(T);
        m_scl = 1'b0; wt(T);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wt(T);
        m_scl = 1'b1; wt(T);
        m_sda = 1'b1; wt(2*T);
    endtask

    task automatic bit_w(input logic v);
        m_sda = v; wt(T);
        m_scl = 1'b1; wt(2*T);
        m_scl = 1'b0; wt(T);
    endtask

    task automatic bit_r(output logic v);
        m_sda = 1'b1; wt(T);
        m_scl = 1'b1; wt(T);
        v = sda_bus; wt(T);
        m_scl = 1'b0; wt(T);
    endtask

    task automatic byte_w(input logic [7:0] v, output logic a);
        logic s;
        for (int i = 7; i >= 0; i--) bit_w(v[i]);
        bit_r(s);
        a = ~s;
    endtask

    task automatic byte_r(input logic mack, output logic [7:0] v);
        for (int i = 7; i >= 0; i--) bit_r(v[i]);
        bit_w(~mack);
    endtask

    initial begin
        wt(5);
        chk("rst_scl_oen", {7'd0, scl_oen}, 8'h01);
        chk("rst_sda_oen", {7'd0, sda_oen}, 8'h01);
        chk("rst_cfg", cfg_reg, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_done", {7'd0, xfer_done}, 8'h00);
        rst = 1'b0;
        wt(T);

        // ID read through repeated START
        i2c_start();
        byte_w(8'h96, ack); chk("id_addr_ack", {7'd0, ack}, 8'h01);
        chk("id_busy", {7'd0, busy}, 8'h01);
        byte_w(8'h0B, ack); chk("id_ptr_ack", {7'd0, ack}, 8'h01);
        i2c_rstart();
        byte_w(8'h97, ack); chk("id_raddr_ack", {7'd0, ack}, 8'h01);
        byte_r(1'b0, d);   chk("id_data", d, 8'hCB);
        i2c_stop();
        chk("id_done_cnt", 8'(done_cnt), 8'd1);
        chk("id_busy_after", {7'd0, busy}, 8'h00);

        // Foreign address must be ignored
        done_ref = done_cnt;
        sda_low_seen = 1'b0;
        mon_en = 1'b1;
        i2c_start();
        byte_w(8'h90, ack); chk("nack_ack", {7'd0, ack}, 8'h00);
        chk("nack_busy", {7'd0, busy}, 8'h00);
        i2c_stop();
        mon_en = 1'b0;
        chk("nack_sda_low", {7'd0, sda_low_seen}, 8'h00);
        chk("nack_done", 8'(done_cnt - done_ref), 8'd0);

        // 25.0 C
        temp_c16 = 13'h190; temp_load = 1'b1; wt(1); temp_load = 1'b0;
        i2c_start();
        byte_w(8'h96, ack); byte_w(8'h00, ack);
        i2c_rstart();
        byte_w(8'h97, ack);
        byte_r(1'b1, d); chk("t25_msb", d, 8'h0C);
        byte_r(1'b0, d); chk("t25_lsb", d, 8'h80);
        i2c_stop();

        // temp_load between MSB and LSB must not tear
        i2c_start();
        byte_w(8'h96, ack); byte_w(8'h00, ack);
        i2c_rstart();
        byte_w(8'h97, ack);
        byte_r(1'b1, d); chk("tear_msb", d, 8'h0C);
        temp_c16 = 13'h0A0; temp_load = 1'b1; wt(1); temp_load = 1'b0;
        byte_r(1'b0, d); chk("tear_lsb", d, 8'h80);
        i2c_stop();
        i2c_start();
        byte_w(8'h96, ack); byte_w(8'h00, ack);
        i2c_rstart();
        byte_w(8'h97, ack);
        byte_r(1'b1, d); chk("t10_msb", d, 8'h05);
        byte_r(1'b0, d); chk("t10_lsb", d, 8'h00);
        i2c_stop();

        // Pointer wraps 0xFF -> 0x00
        i2c_start();
        byte_w(8'h96, ack); byte_w(8'hFF, ack);
        i2c_rstart();
        byte_w(8'h97, ack);
        byte_r(1'b1, d); chk("wrap_ff", d, 8'h00);
        byte_r(1'b0, d); chk("wrap_00", d, 8'h05);
        i2c_stop();

        // Config write, then a truncated write
        i2c_start();
        byte_w(8'h96, ack); byte_w(8'h03, ack);
        byte_w(8'h80, ack); chk("cfg_data_ack", {7'd0, ack}, 8'h01);
        i2c_stop();
        chk("cfg_written", cfg_reg, 8'h80);
        i2c_start();
        byte_w(8'h96, ack); byte_w(8'h03, ack);
        bit_w(1'b0); bit_w(1'b1); bit_w(1'b0); bit_w(1'b1);
        i2c_stop();
        chk("cfg_partial", cfg_reg, 8'h80);

        // Auto-increment read: status then config
        i2c_start();
        byte_w(8'h96, ack); byte_w(8'h02, ack);
        i2c_rstart();
        byte_w(8'h97, ack);
        byte_r(1'b1, d); chk("inc_status", d, 8'h00);
        byte_r(1'b0, d); chk("inc_cfg", d, 8'h80);
        i2c_stop();

        // Reset while the target is driving a 0 data bit
        i2c_start();
        byte_w(8'h96, ack); byte_w(8'h02, ack);
        i2c_rstart();
        byte_w(8'h97, ack);
        bit_r(b); bit_r(b);
        m_sda = 1'b1; wt(T);
        m_scl = 1'b1; wt(T);
        chk("rdata_drive", {7'd0, sda_oen}, 8'h00);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("arst_sda_oen", {7'd0, sda_oen}, 8'h01);
        chk("arst_cfg", cfg_reg, 8'h00);
        chk("arst_busy", {7'd0, busy}, 8'h00);
        wt(5);
        rst = 1'b0;
        m_scl = 1'b1; m_sda = 1'b1;
        wt(4*T);
        i2c_start();
        byte_w(8'h96, ack); chk("post_addr_ack", {7'd0, ack}, 8'h01);
        byte_w(8'h0B, ack);
        i2c_rstart();
        byte_w(8'h97, ack);
        byte_r(1'b1, d); chk("post_id", d, 8'hCB);
        byte_r(1'b0, d); chk("post_next", d, 8'h00);
        i2c_stop();
        chk("post_scl_oen", {7'd0, scl_oen}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
